phase_accum_ram: RTL and testbench

PHASE_ACCUM_RAM -- requirements
Module: phase_accum_ram

---
 rtl/phase_accum_ram_pkg.sv | 14 +
 rtl/phase_pos_ram.sv | 34 +++
 rtl/phase_accum_ram.sv | 201 ++++++++++++++++++++
 tb/tb_phase_accum_ram.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/phase_accum_ram_pkg.sv
// Shared types and default widths for the harmonic phase accumulator.
package phase_accum_ram_pkg;

    localparam int unsigned PA_ADDR_WIDTH = 8;
    localparam int unsigned PA_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } pa_state_e;

endpackage

// File: rtl/phase_pos_ram.sv
// Position storage: one write port and one registered read port, usable in the same cycle.
module phase_pos_ram
    import phase_accum_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PA_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are established by the controller's clear pass, so no reset here.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/phase_accum_ram.sv
// Harmonic phase accumulator: each sweep adds (n+1)*freq_inc to entry n of a position RAM.
// Optional hard-sync input enabled by defining PHASE_SYNC_EN.
module phase_accum_ram
    import phase_accum_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PA_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PA_DATA_WIDTH,
    parameter int unsigned HARM_COUNT = 1 << PA_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] freq_inc,
`ifdef PHASE_SYNC_EN
    input  logic                  sync,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  pos_valid,
    output logic [ADDR_WIDTH-1:0] pos_index,
    output logic [DATA_WIDTH-1:0] pos
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(HARM_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    pa_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] inc_q, inc_d;
    logic [DATA_WIDTH-1:0] harm_q, harm_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pv_q, pv_d;
    logic [ADDR_WIDTH-1:0] pidx_q, pidx_d;
    logic [DATA_WIDTH-1:0] pos_q, pos_d;

    logic                  wr_en_c;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  start_acc_c;
    logic                  zero_c;

    // A start that coincides with the done pulse is dropped.
    assign start_acc_c = (state_q == IDLE) && start && !done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            inc_q   <= '0;
            harm_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pv_q    <= 1'b0;
            pidx_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            inc_q   <= inc_d;
            harm_q  <= harm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        inc_d     = inc_q;
        harm_d    = harm_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pv_d      = 1'b0;
        pidx_d    = pidx_q;
        pos_d     = pos_q;
        wr_en_c   = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;

        case (state_q)
            IDLE: begin
                if (start_acc_c) begin
                    state_d   = SWEEP;
                    inc_d     = freq_inc;
                    harm_d    = freq_inc;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    ram_re    = 1'b1;
                    ram_raddr = '0;
                end
            end
            CLEAR: begin
                wr_en_c   = 1'b1;
                ram_wdata = '0;
                idx_d     = idx_q + ADDR_WIDTH'(1);
                if (idx_q == LAST_ADDR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                // Entry n is written while entry n+1 is fetched; harm_q holds (n+1)*inc.
                wr_en_c   = 1'b1;
                ram_wdata = zero_c ? '0 : DATA_WIDTH'(ram_rdata + harm_q);
                harm_d    = DATA_WIDTH'(harm_q + inc_q);
                pv_d      = 1'b1;
                pidx_d    = idx_q;
                pos_d     = ram_rdata;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d     = idx_q + ADDR_WIDTH'(1);
                    ram_re    = 1'b1;
                    ram_raddr = idx_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                idx_d   = '0;
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

`ifdef PHASE_SYNC_EN
    logic pend_q, pend_d;
    logic zero_q, zero_d;

    // Pending sync is armed in IDLE/SWEEP and consumed by the next sweep that starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            zero_q <= zero_d;
        end
    end

    always_comb begin
        pend_d = pend_q;
        zero_d = zero_q;
        if (start_acc_c) begin
            zero_d = pend_q | sync;
        end
        if (state_q == DONE) begin
            zero_d = 1'b0;
            if (zero_q) begin
                pend_d = 1'b0;
            end
        end
        if (sync && ((state_q == IDLE) || (state_q == SWEEP))) begin
            pend_d = 1'b1;
        end
    end

    assign zero_c = zero_q;
`else
    assign zero_c = 1'b0;
`endif

    assign ram_we = wr_en_c & ~reset;

    phase_pos_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign pos_valid = pv_q;
    assign pos_index = pidx_q;
    assign pos       = pos_q;

endmodule

// File: tb/tb_phase_accum_ram.sv
// Directed bench for phase_accum_ram (HARM_COUNT=4, 256-entry RAM); sync cases need PHASE_SYNC_EN.
module tb_phase_accum_ram;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] freq_inc;
`ifdef PHASE_SYNC_EN
    logic        sync;
`endif
    logic        busy;
    logic        done;
    logic        pos_valid;
    logic [7:0]  pos_index;
    logic [15:0] pos;

    int unsigned n_checks;
    int unsigned n_fails;
    logic [15:0] ev [4];

    phase_accum_ram #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (16),
        .HARM_COUNT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .freq_inc  (freq_inc),
`ifdef PHASE_SYNC_EN
        .sync      (sync),
`endif
        .busy      (busy),
        .done      (done),
        .pos_valid (pos_valid),
        .pos_index (pos_index),
        .pos       (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One sweep of 4 entries; checks pos stream, busy and the done pulse cycle by cycle.
    task automatic do_sweep(input string tag, input logic [15:0] inc, input logic [15:0] exp_pos [4],
                            input bit hold_start, input bit pulse_sync);
        freq_inc = inc;
        start    = 1'b1;
        tick();
        if (hold_start) freq_inc = ~inc;
        else            start    = 1'b0;
        check({tag, ":busy_t1"}, 32'(busy), 1);
        check({tag, ":pv_t1"}, 32'(pos_valid), 0);
        for (int n = 0; n < 4; n++) begin
            if (pulse_sync && n == 1) begin
`ifdef PHASE_SYNC_EN
                sync = 1'b1;
`endif
            end
            tick();
`ifdef PHASE_SYNC_EN
            sync = 1'b0;
`endif
            check($sformatf("%s:pv%0d", tag, n), 32'(pos_valid), 1);
            check($sformatf("%s:idx%0d", tag, n), 32'(pos_index), 32'(n));
            check($sformatf("%s:pos%0d", tag, n), 32'(pos), 32'(exp_pos[n]));
            check($sformatf("%s:busy%0d", tag, n), 32'(busy), 1);
            check($sformatf("%s:nodone%0d", tag, n), 32'(done), 0);
        end
        tick();
        check({tag, ":done"}, 32'(done), 1);
        check({tag, ":busy_at_done"}, 32'(busy), 0);
        check({tag, ":pv_at_done"}, 32'(pos_valid), 0);
        start = 1'b0;
        tick();
        check({tag, ":done_pulse_end"}, 32'(done), 0);
        check({tag, ":idle_after"}, 32'(busy), 0);
    endtask

    // Full-depth clear; start held throughout to show it is ignored.
    task automatic run_clear(input string tag);
        start = 1'b1;
        repeat (255) tick();
        check({tag, ":busy_255"}, 32'(busy), 1);
        tick();
        check({tag, ":busy_256"}, 32'(busy), 0);
        check({tag, ":done_256"}, 32'(done), 0);
        start = 1'b0;
        tick();
        check({tag, ":idle_257"}, 32'(busy), 0);
        check({tag, ":pv_257"}, 32'(pos_valid), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        start    = 1'b0;
        freq_inc = 16'h0000;
`ifdef PHASE_SYNC_EN
        sync     = 1'b0;
`endif
        tick();
        check("rst:busy", 32'(busy), 1);
        check("rst:done", 32'(done), 0);
        check("rst:pv", 32'(pos_valid), 0);
        check("rst:idx", 32'(pos_index), 0);
        check("rst:pos", 32'(pos), 0);
        reset = 1'b0;
        run_clear("clr0");

        ev = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        do_sweep("zero_inc", 16'h0000, ev, 1'b0, 1'b0);
        do_sweep("inc100_a", 16'h0100, ev, 1'b0, 1'b0);
        ev = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        do_sweep("inc100_b", 16'h0100, ev, 1'b0, 1'b0);

        ev = '{16'h0200, 16'h0400, 16'h0600, 16'h0800};
        do_sweep("hold_start", 16'h0001, ev, 1'b1, 1'b0);
        ev = '{16'h0201, 16'h0402, 16'h0603, 16'h0804};
        do_sweep("after_hold", 16'h0000, ev, 1'b0, 1'b0);

        // Abort a sweep with reset just before entry 2 is reported.
        freq_inc = 16'h0010;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort:pos0", 32'(pos), 32'h0201);
        tick();
        check("abort:pos1", 32'(pos), 32'h0402);
        reset = 1'b1;
        tick();
        check("abort:pv_drop", 32'(pos_valid), 0);
        check("abort:busy", 32'(busy), 1);
        check("abort:pos_clr", 32'(pos), 0);
        reset = 1'b0;
        run_clear("clr1");

        ev = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        do_sweep("post_clr", 16'h8000, ev, 1'b0, 1'b0);
        ev = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
        do_sweep("wrap", 16'h0000, ev, 1'b0, 1'b0);

`ifdef PHASE_SYNC_EN
        do_sweep("sync_arm", 16'h0001, ev, 1'b0, 1'b1);
        ev = '{16'h8001, 16'h0002, 16'h8003, 16'h0004};
        do_sweep("sync_zero", 16'h0001, ev, 1'b0, 1'b0);
        ev = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        do_sweep("sync_from0", 16'h0010, ev, 1'b0, 1'b0);
        ev = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        do_sweep("sync_after", 16'h0000, ev, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
